alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised, registered successor of the single-cycle MIPS ALU. Sits between operand selection (register file / B-operand mux) and write-back / data-memory address path.
- Adds shifts, a signed/unsigned compare split, signed overflow detection, an optional iterative multi-cycle multiply, and valid/ready handshakes on both sides, so the datapath can stall on a busy or back-pressured ALU.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 8.
- SHW, $clog2(WIDTH), shift-amount width, derived; not overridden.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RESET_N  in  1  synchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- ALUCtl  in  4  operation code
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount for shifts
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes the result this cycle
- ALUOut  out  WIDTH  registered result
- Zero  out  1  registered (ALUOut == 0)
- Overflow  out  1  registered signed overflow (ADD/SUB only)
- Illegal  out  1  registered: ALUCtl was unsupported
- busy  out  1  multiply in progress

Behaviour:
- Reset: with RESET_N low at a rising CLK edge: state=IDLE, out_valid=0, ALUOut=0, Zero=0, Overflow=0, Illegal=0, busy=0, multiply counter=0. Reset mid-multiply abandons the operation; no result is produced.
- Encoding:
  - 0 AND; 1 OR; 2 ADD; 3 SLL; 4 SRL; 5 SRA
  - 6 SUB; 7 SLT (signed); 8 SLTU (unsigned); 9 MUL (low WIDTH bits); 12 NOR
  - Any other code: ALUOut=0, Illegal=1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Overflow=1 iff the operand signs make the signed result unrepresentable. Overflow=0 for all other ops.
  - SLT/SLTU yield 1 or 0, zero-extended.
  - Shifts use only B[SHW-1:0]; SRA replicates A[WIDTH-1].
- Handshake:
  - Accept = in_valid && in_ready.
  - Release = out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready), so a release and a new accept may occur in the same cycle.
  - Inputs are sampled only at accept; A, B and ALUCtl are don't-care otherwise.
  - While out_valid=1 and out_ready=0, ALUOut, Zero, Overflow and Illegal are held stable.
  - out_valid falls after a release edge unless a new result is written at the same edge.
- FSM, states IDLE and MUL:
  - IDLE, accept of a single-cycle op: result registered at the accept edge; out_valid=1 after it (latency 1). Throughput 1 op/cycle when out_ready is held high.
  - IDLE, accept of MUL: load multiplicand=A, multiplier=B, acc=0, cnt=0; go to MUL; busy=1.
  - MUL, each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++.
  - MUL, at the edge where cnt==WIDTH-1: write the final acc to ALUOut, set out_valid=1, return to IDLE, busy=0. MUL latency = WIDTH cycles after the accept edge.
  - In MUL, in_ready=0.
  - MUL is entered only when the output register is free, so completion never overwrites an unconsumed result.

Optional Feature:
- ALU_MUL_EN defined: MUL (code 9) implemented as above, with the MUL state, counter and accumulator present.
- ALU_MUL_EN undefined: no MUL state or hardware; code 9 is treated as illegal (1-cycle, ALUOut=0, Illegal=1); busy is tied to 0.

Test Plan:
- Reset: hold RESET_N=0 for 2 cycles with in_valid=1 -> out_valid=0, ALUOut=0, Zero=0, in_ready=1 after release.
- Single-cycle ops, WIDTH=32, out_ready=1, back-to-back:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, Overflow=1
  - SUB 5-5 -> 0, Zero=1
  - SLT 0xFFFFFFFF<1 -> 1
  - SLTU 0xFFFFFFFF<1 -> 0
  - SRA 0x80000000 by 4 -> 0xF8000000
  - NOR 0,0 -> 0xFFFFFFFF
  - one result per cycle.
- Back-pressure: ADD 3+4 with out_ready=0 for 3 cycles -> ALUOut=7 held, in_ready=0; out_ready=1 with a simultaneous AND 0xC & 0xA accept -> next cycle ALUOut=8.
- MUL with ALU_MUL_EN: 0x1234 * 0x10 -> 0x12340 exactly 32 cycles after accept; busy=1 and in_ready=0 throughout; 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
- Reset mid-MUL: RESET_N=0 at cycle 10 of a MUL -> no out_valid ever for it; the next ADD 1+1 -> 2 with latency 1.
- Illegal: ALUCtl=15 -> ALUOut=0, Illegal=1, Zero=1; without ALU_MUL_EN, ALUCtl=9 -> Illegal=1 with latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered ALU with valid/ready handshakes, optional iterative MUL
// Optional feature macro: ALU_MUL_EN (multi-cycle shift-add multiply on ALUCtl=9).
module alu_exec_unit #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal,
  output logic             busy
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd12;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff, res;
  logic             ovf, ill;
  logic             in_fire, out_fire, single_fire;

  assign shamt    = B[SHW-1:0];
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    sum  = A + B;
    diff = A - B;
    res  = '0;
    ovf  = 1'b0;
    ill  = 1'b0;
    case (ALUCtl)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_ADD: begin
        res = sum;
        ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  res = A << shamt;
      OP_SRL:  res = A >> shamt;
      OP_SRA:  res = $unsigned($signed(A) >>> shamt);
      OP_SUB: begin
        res = diff;
        ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_NOR:  res = ~(A | B);
      default: ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [SHW-1:0]   cnt;

  assign acc_next    = mplier[0] ? acc + mcand : acc;
  assign in_ready    = (state == ST_IDLE) && (!out_valid || out_ready);
  assign busy        = (state == ST_MUL);
  assign single_fire = in_fire && (ALUCtl != OP_MUL);
`else
  assign in_ready    = !out_valid || out_ready;
  assign busy        = 1'b0;
  assign single_fire = in_fire;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      out_valid <= 1'b0;
      ALUOut    <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      Illegal   <= 1'b0;
`ifdef ALU_MUL_EN
      state  <= ST_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`endif
    end else begin
      if (out_fire) out_valid <= 1'b0;
      if (single_fire) begin
        ALUOut    <= res;
        Zero      <= (res == '0);
        Overflow  <= ovf;
        Illegal   <= ill;
        out_valid <= 1'b1;
      end
`ifdef ALU_MUL_EN
      // in_ready is low in MUL, so the single-cycle write above never collides with this
      if (state == ST_MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + SHW'(1);
        if (cnt == SHW'(WIDTH - 1)) begin
          ALUOut    <= acc_next;
          Zero      <= (acc_next == '0);
          Overflow  <= 1'b0;
          Illegal   <= 1'b0;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
          cnt       <= '0;
        end
      end else if (in_fire && (ALUCtl == OP_MUL)) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
        state  <= ST_MUL;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed + randomized check of alu_exec_unit against a transaction-level model
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_out;
  logic         zero, ovf, ill, busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  alu_exec_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUCtl(op), .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .ALUOut(alu_out), .Zero(zero), .Overflow(ovf), .Illegal(ill), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics straight from the ISA description, using wide signed arithmetic.
  function automatic void ref_alu(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic v, output logic il);
    longint sx, sy, s;
    logic [63:0] p;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    r = '0; v = 1'b0; il = 1'b0;
    case (o)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin s = sx + sy; r = s[W-1:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3: r = x << sh;
      4'd4: r = x >> sh;
      4'd5: begin s = sx >>> sh; r = s[W-1:0]; end
      4'd6: begin s = sx - sy; r = s[W-1:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7: r = (sx < sy) ? 1 : 0;
      4'd8: r = (x < y) ? 1 : 0;
      4'd9: begin
        if (MUL_EN) begin p = {32'b0, x} * {32'b0, y}; r = p[W-1:0]; end
        else il = 1'b1;
      end
      4'd12: r = ~(x | y);
      default: il = 1'b1;
    endcase
  endfunction

  // Transaction-level model: one output slot, plus a countdown for an in-flight multiply.
  logic         m_valid = 1'b0, m_zero = 1'b0, m_ovf = 1'b0, m_ill = 1'b0;
  logic [W-1:0] m_out = '0, m_pend = '0;
  int           m_left = 0;

  always @(posedge CLK) begin
    logic         rdy, v, il;
    logic [W-1:0] r;
    if (!rst_n) begin
      m_valid <= 1'b0; m_out <= '0; m_zero <= 1'b0; m_ovf <= 1'b0; m_ill <= 1'b0; m_left <= 0;
    end else begin
      rdy = (m_left == 0) && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid <= 1'b1; m_out <= m_pend; m_zero <= (m_pend == 0); m_ovf <= 1'b0; m_ill <= 1'b0;
        end
      end else if (in_valid && rdy) begin
        ref_alu(op, a, b, r, v, il);
        if (op == 4'd9 && MUL_EN) begin
          m_pend <= r;
          m_left <= W;
        end else begin
          m_valid <= 1'b1; m_out <= r; m_zero <= (r == 0); m_ovf <= v; m_ill <= il;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("in_ready", W'(in_ready), W'((m_left == 0) && (!m_valid || out_ready)));
      check("out_valid", W'(out_valid), W'(m_valid));
      check("busy", W'(busy), W'(m_left > 0));
      if (m_valid) begin
        check("ALUOut", alu_out, m_out);
        check("Zero", W'(zero), W'(m_zero));
        check("Overflow", W'(ovf), W'(m_ovf));
        check("Illegal", W'(ill), W'(m_ill));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0]   d_op [6] = '{4'd2, 4'd6, 4'd7, 4'd8, 4'd5, 4'd12};
  logic [W-1:0] d_a  [6] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0};
  logic [W-1:0] d_b  [6] = '{32'h1, 32'd5, 32'h1, 32'h1, 32'd4, 32'h0};
  logic [W-1:0] d_r  [6] = '{32'h80000000, 32'h0, 32'h1, 32'h0, 32'hF8000000, 32'hFFFFFFFF};
  logic [3:0]   r_ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd10, 4'd15};
  logic [W-1:0] corner [4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0};

  function automatic logic [W-1:0] rnd_operand();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  initial begin
    logic [W-1:0] r;
    logic v, il;

    // Pin the model against hand-computed values.
    ref_alu(4'd2, 32'h7FFFFFFF, 32'h1, r, v, il);
    check("model_add_r", r, 32'h80000000);
    check("model_add_v", W'(v), 1);
    ref_alu(4'd5, 32'h80000000, 32'd4, r, v, il);
    check("model_sra", r, 32'hF8000000);
    ref_alu(4'd7, 32'hFFFFFFFF, 32'h1, r, v, il);
    check("model_slt", r, 32'h1);
    ref_alu(4'd6, 32'h80000000, 32'h1, r, v, il);
    check("model_sub_v", W'(v), 1);

    // Reset held with a request pending.
    rst_n = 1'b0; in_valid = 1'b1; op = 4'd2; a = 1; b = 1;
    tick(); tick();
    rst_n = 1'b1; in_valid = 1'b0;
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_aluout", alu_out, 0);
    check("rst_zero", W'(zero), 0);
    check("rst_in_ready", W'(in_ready), 1);
    chk_en = 1'b1;

    // Back-to-back single-cycle ops, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; op = d_op[i]; a = d_a[i]; b = d_b[i];
      tick();
      check($sformatf("b2b_%0d_valid", i), W'(out_valid), 1);
      check($sformatf("b2b_%0d_out", i), alu_out, d_r[i]);
      if (i == 0) check("b2b_add_ovf", W'(ovf), 1);
      if (i == 1) check("b2b_sub_zero", W'(zero), 1);
    end
    in_valid = 1'b0;

    // Back-pressure, then release with a simultaneous accept.
    tick();
    out_ready = 1'b0; in_valid = 1'b1; op = 4'd2; a = 3; b = 4;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_out", alu_out, 7);
      check("bp_in_ready", W'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'hC; b = 32'hA;
    #1;
    check("bp_release_ready", W'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_and_out", alu_out, 8);

    // Illegal opcode, and code 9 when multiply is not built.
    in_valid = 1'b1; op = 4'd15; a = 32'h55; b = 32'h66;
    tick();
    in_valid = 1'b0;
    check("ill15_out", alu_out, 0);
    check("ill15_ill", W'(ill), 1);
    check("ill15_zero", W'(zero), 1);
    if (!MUL_EN) begin
      in_valid = 1'b1; op = 4'd9; a = 3; b = 3;
      tick();
      in_valid = 1'b0;
      check("ill9_valid", W'(out_valid), 1);
      check("ill9_ill", W'(ill), 1);
      check("ill9_out", alu_out, 0);
    end else begin
      in_valid = 1'b1; op = 4'd9; a = 32'h1234; b = 32'h10;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < W; k++) begin
        check("mul_busy", W'(busy), 1);
        check("mul_in_ready", W'(in_ready), 0);
        tick();
      end
      check("mul_valid", W'(out_valid), 1);
      check("mul_out", alu_out, 32'h12340);
      in_valid = 1'b1; op = 4'd9; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      tick();
      in_valid = 1'b0;
      repeat (W) tick();
      check("mul_sq_out", alu_out, 32'h1);
      // Abandon a multiply with reset at its 10th cycle.
      in_valid = 1'b1; op = 4'd9; a = 32'h77; b = 32'h99;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < W + 8; k++) begin
        check("mul_rst_no_valid", W'(out_valid), 0);
        tick();
      end
      in_valid = 1'b1; op = 4'd2; a = 1; b = 1;
      tick();
      in_valid = 1'b0;
      check("post_rst_add", alu_out, 2);
      check("post_rst_valid", W'(out_valid), 1);
    end

    // Randomized traffic with back-pressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      op = r_ops[$urandom_range(0, 12)];
      a  = rnd_operand();
      b  = rnd_operand();
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
